// File: rtl/tlb_cmd_engine_if.sv
// -----------------------------------------------------------------------------
// tlb_cmd_engine_if
// Command/response handshake bundle between the CSR/TLB-instruction logic
// (master) and tlb_cmd_engine (slave).
//
// Signals:
//   cmd_valid / cmd_ready   command handshake
//   cmd_op                  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV, 5-7 illegal
//   cmd_index               RD/WR index
//   cmd_entry               WR/FILL entry (packed 89-bit ENT)
//   cmd_vppn / cmd_va_bit12 / cmd_asid / cmd_invop   SRCH/INV operands
//   rsp_valid / rsp_ready   response handshake
//   rsp_found / rsp_index / rsp_entry / rsp_err / rsp_inv_cnt   results
// -----------------------------------------------------------------------------
interface tlb_cmd_engine_if #(
    parameter int unsigned TLBNUM = 16
);
    localparam int unsigned IW = $clog2(TLBNUM);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [IW-1:0] cmd_index;
    logic [88:0]   cmd_entry;
    logic [18:0]   cmd_vppn;
    logic          cmd_va_bit12;
    logic [9:0]    cmd_asid;
    logic [4:0]    cmd_invop;

    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_found;
    logic [IW-1:0] rsp_index;
    logic [88:0]   rsp_entry;
    logic          rsp_err;
    logic [IW:0]   rsp_inv_cnt;

    modport master (
        output cmd_valid, cmd_op, cmd_index, cmd_entry, cmd_vppn, cmd_va_bit12,
               cmd_asid, cmd_invop, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_found, rsp_index, rsp_entry, rsp_err,
               rsp_inv_cnt
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_index, cmd_entry, cmd_vppn, cmd_va_bit12,
               cmd_asid, cmd_invop, rsp_ready,
        output cmd_ready, rsp_valid, rsp_found, rsp_index, rsp_entry, rsp_err,
               rsp_inv_cnt
    );
endinterface

// File: rtl/tlb_cmd_engine.sv
// -----------------------------------------------------------------------------
// tlb_cmd_engine
// Initiator side of the TLB: executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB
// against a combinational TLB through its search port 1, read port and write
// port. INVTLB walks every entry (read, evaluate, write back with e=0), one
// entry per two cycles.
//
// Optional feature macro: TLB_FILL_LFSR_EN
//   defined   : FILL index = low IW bits of a 16-bit Fibonacci LFSR
//               (taps 16,14,13,11, seed 16'hACE1, advances every clock)
//   undefined : FILL index = round-robin counter, advanced after each FILL
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   bus (tlb_cmd_engine_if.slave)    command / response handshake
//   s_vppn, s_va_bit12, s_asid       -> TLB search port 1
//   s_found, s_index                 <- TLB search port 1
//   r_index / r_entry                -> / <- TLB read port
//   we, w_index, w_entry             -> TLB write port
//
// ENT layout: [88]e [87:69]vppn [68:63]ps [62:53]asid [52]g [51:32]ppn0
//   [31:30]plv0 [29:28]mat0 [27]d0 [26]v0 [25:6]ppn1 [5:4]plv1 [3:2]mat1
//   [1]d1 [0]v1
// -----------------------------------------------------------------------------
module tlb_cmd_engine #(
    parameter  int unsigned TLBNUM = 16,
    localparam int unsigned IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    tlb_cmd_engine_if.slave bus,
    output logic [18:0]   s_vppn,
    output logic          s_va_bit12,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic [88:0]   r_entry,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [88:0]   w_entry
);

    typedef enum logic [2:0] {StIdle, StExec, StInvRd, StInvWr, StResp} state_e;

    state_e        r_state;
    logic          r_cmd_ready;
    logic [2:0]    r_op;
    logic [18:0]   r_vppn;
    logic [9:0]    r_asid;
    logic [4:0]    r_invop;
    logic [IW-1:0] r_walk;
    logic [IW:0]   r_inv_cnt;
    logic          r_rsp_valid;
    logic          r_rsp_found;
    logic [IW-1:0] r_rsp_index;
    logic [88:0]   r_rsp_entry;
    logic          r_rsp_err;

    logic          w_illegal;
    logic [IW-1:0] w_fill_idx;
    logic          w_g;
    logic          w_a;
    logic          w_v;
    logic          w_hit;

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_found   = r_rsp_found;
    assign bus.rsp_index   = r_rsp_index;
    assign bus.rsp_entry   = r_rsp_entry;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_inv_cnt = r_inv_cnt;

    // Ops 5-7 are undefined; INVTLB only defines invop 0..6.
    assign w_illegal = (bus.cmd_op > 3'd4) || ((bus.cmd_op == 3'd4) && (bus.cmd_invop > 5'd6));

    // INVTLB match terms for the entry currently on the read port.
    assign w_g = r_entry[52];
    assign w_a = (r_entry[62:53] == r_asid);
    // A 4 MB page (ps=21) ignores the low 10 vppn bits.
    assign w_v = (r_entry[87:79] == r_vppn[18:10]) &&
                 ((r_entry[68:63] == 6'd21) || (r_entry[78:69] == r_vppn[9:0]));

    always_comb begin
        w_hit = 1'b0;
        case (r_invop)
            5'd0, 5'd1: w_hit = 1'b1;
            5'd2:       w_hit = w_g;
            5'd3:       w_hit = !w_g;
            5'd4:       w_hit = !w_g && w_a;
            5'd5:       w_hit = !w_g && w_a && w_v;
            5'd6:       w_hit = (w_g || w_a) && w_v;
            default:    w_hit = 1'b0;
        endcase
        w_hit = w_hit && r_entry[88];
    end

`ifdef TLB_FILL_LFSR_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_fill_idx = r_lfsr[IW-1:0];
`else
    logic [IW-1:0] r_fill_cnt;
    logic          w_fill_take;

    assign w_fill_take = r_cmd_ready && bus.cmd_valid && (bus.cmd_op == 3'd3);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill_cnt <= '0;
        end else if (w_fill_take) begin
            r_fill_cnt <= (r_fill_cnt == IW'(TLBNUM - 1)) ? '0 : r_fill_cnt + IW'(1);
        end
    end

    assign w_fill_idx = r_fill_cnt;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b1;
            r_op        <= '0;
            r_vppn      <= '0;
            r_asid      <= '0;
            r_invop     <= '0;
            r_walk      <= '0;
            r_inv_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_found <= 1'b0;
            r_rsp_index <= '0;
            r_rsp_entry <= '0;
            r_rsp_err   <= 1'b0;
            s_vppn      <= '0;
            s_va_bit12  <= 1'b0;
            s_asid      <= '0;
            r_index     <= '0;
            we          <= 1'b0;
            w_index     <= '0;
            w_entry     <= '0;
        end else begin
            // TLB port drives are idle unless the next state needs them,
            // so at most one port is active in any cycle.
            s_vppn     <= '0;
            s_va_bit12 <= 1'b0;
            s_asid     <= '0;
            r_index    <= '0;
            we         <= 1'b0;
            w_index    <= '0;
            w_entry    <= '0;

            case (r_state)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= bus.cmd_op;
                        r_vppn      <= bus.cmd_vppn;
                        r_asid      <= bus.cmd_asid;
                        r_invop     <= bus.cmd_invop;
                        r_rsp_found <= 1'b0;
                        r_rsp_index <= '0;
                        r_rsp_entry <= '0;
                        if (w_illegal) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end else if (bus.cmd_op == 3'd4) begin
                            r_walk    <= '0;
                            r_inv_cnt <= '0;
                            r_index   <= '0;
                            r_state   <= StInvRd;
                        end else begin
                            r_state <= StExec;
                            case (bus.cmd_op)
                                3'd0: begin
                                    s_vppn     <= bus.cmd_vppn;
                                    s_va_bit12 <= bus.cmd_va_bit12;
                                    s_asid     <= bus.cmd_asid;
                                end
                                3'd1: r_index <= bus.cmd_index;
                                3'd2: begin
                                    we      <= 1'b1;
                                    w_index <= bus.cmd_index;
                                    w_entry <= bus.cmd_entry;
                                end
                                3'd3: begin
                                    we      <= 1'b1;
                                    w_index <= w_fill_idx;
                                    w_entry <= bus.cmd_entry;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                StExec: begin
                    case (r_op)
                        3'd0: begin
                            r_rsp_found <= s_found;
                            r_rsp_index <= s_index;
                        end
                        3'd1:    r_rsp_entry <= r_entry;
                        3'd3:    r_rsp_index <= w_index;
                        default: ;
                    endcase
                    r_rsp_valid <= 1'b1;
                    r_state     <= StResp;
                end

                StInvRd: begin
                    if (w_hit) begin
                        we        <= 1'b1;
                        w_index   <= r_walk;
                        w_entry   <= {1'b0, r_entry[87:0]};
                        r_inv_cnt <= r_inv_cnt + (IW + 1)'(1);
                    end
                    r_state <= StInvWr;
                end

                StInvWr: begin
                    if (r_walk == IW'(TLBNUM - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_walk  <= r_walk + IW'(1);
                        r_index <= r_walk + IW'(1);
                        r_state <= StInvRd;
                    end
                end

                StResp: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_inv_cnt   <= '0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end

                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= StIdle;
                end
            endcase
        end
    end

endmodule
